iob_mem_tiled_ctrl: RTL and testbench
=====================================

Name: iob_mem_tiled_ctrl

Overview:
- Multi-requester controller that shares one tiled single-address 2-port memory between N_REQ masters.
- Round-robin arbitration, per-requester valid/ready request handshake and a registered read-response pulse.
- Holds the memory address stable across the read-data cycle, because the tiled memory's output bank mux is steered by the live address.
- Sits between core/DMA masters and the tiled memory instance.

Parameters:
- N_REQ, 2, number of requesters (>=1).
- DATA_W, 32, data width; equals the memory DATA_W.
- ADDR_W, 15, memory address width; equals the memory ADDR_W.
- IDX_W, (N_REQ>1 ? $clog2(N_REQ) : 1), requester index width; derived, do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  flattened write data
- req_ready  out  N_REQ  one-hot grant; handshake when valid&ready
- rsp_valid  out  N_REQ  one-cycle read-data pulse to the issuing requester
- rsp_rdata  out  DATA_W  read data; valid while any rsp_valid bit is high
- mem_w_en  out  1  to memory w_en
- mem_r_en  out  1  to memory r_en
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  DATA_W  to memory data_in
- mem_data_out  in  DATA_W  from memory data_out

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - cmd_we, cmd_addr, cmd_wdata and cmd_id = 0.
  - rsp_valid = 0, rsp_rdata = 0.
  - Last-grant pointer = N_REQ-1, so requester 0 wins first.
  - All outputs 0: req_ready=0, mem_w_en=0, mem_r_en=0, mem_addr=0, mem_data_in=0.
- FSM states: IDLE, ISSUE, RD_HOLD.
- IDLE:
  - If any req_valid, pick winner w and drive req_ready = one-hot(w) combinationally in this cycle.
  - On the clock edge, latch winner's we/addr/wdata and id into the cmd registers, update the last-grant pointer, go to ISSUE.
  - No valid: req_ready = 0, stay IDLE.
- ISSUE:
  - mem_addr = cmd_addr, mem_data_in = cmd_wdata.
  - mem_w_en = cmd_we, mem_r_en = ~cmd_we.
  - Write: next state IDLE. Read: next state RD_HOLD.
- RD_HOLD:
  - mem_addr held at cmd_addr, both enables 0.
  - At the edge: rsp_rdata <= mem_data_out, rsp_valid <= one-hot(cmd_id), next state IDLE.
- rsp_valid is high for exactly one cycle, the cycle after RD_HOLD. rsp_rdata holds its value until the next read completes.
- mem_addr and mem_data_in are driven from the cmd registers in every state, so they never glitch. Enables are high only in ISSUE.
- req_ready is 0 in ISSUE and RD_HOLD.
- Latency, counted from the handshake cycle T:
  - Write: committed to memory at T+1. Next grant possible at T+2.
  - Read: r_en at T+1, data held at T+2, rsp_valid at T+3. Next grant possible at T+3, overlapping with rsp_valid.
- Requesters keep fields stable while valid is high and not ready. Dropping valid before ready is legal; nothing is latched.
- Simultaneous requests: only one grant per IDLE cycle. Losers wait; no starvation under round-robin.
- Read-after-write to the same address: ordered by grant order. A read granted after a write returns the new data.
- Reset mid-operation: an in-flight read is dropped, no rsp_valid is issued, and the pointer returns to N_REQ-1.
- N_REQ=1: arbitration is degenerate and requester 0 is always granted.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. The search starts at last_grant+1 (mod N_REQ), and the pointer updates on every grant.
- Undefined: fixed priority, lowest index wins. The pointer register is not built; requester 0 can starve others.

Test Plan:
1. Write then read, single requester:
   - Stimulus: req0 writes 0xDEADBEEF @0x0010 (handshake T=0), then reads 0x0010.
   - Required: mem_w_en=1 at T+1 with addr 0x0010; rsp_valid[0] pulses 3 cycles after the read handshake with rsp_rdata=0xDEADBEEF.
2. Cross-bank read:
   - Stimulus: write 0x11111111 @0x0004 and 0x22222222 @0x0804 (different tiles); read both back to back.
   - Required: correct data each time; mem_addr stable through RD_HOLD.
3. Contention, MEM_ARB_RR_EN defined:
   - Stimulus: req0 and req1 hold valid continuously, both writing.
   - Required: grants alternate 0,1,0,1; first grant to req0; one grant every 2 cycles.
4. Contention, MEM_ARB_RR_EN undefined:
   - Stimulus: same as scenario 3.
   - Required: req0 granted every time; req1 granted only after req0 drops valid.
5. Reset mid-read:
   - Stimulus: rst_n=0 in RD_HOLD.
   - Required: all outputs 0 immediately; no rsp_valid after release; the next grant goes to req0.
6. Mixed read/write order:
   - Stimulus: req1 reads 0x0010 granted one slot after req0's write of 0xCAFEF00D to the same address.
   - Required: rsp_valid[1] with 0xCAFEF00D; rsp_valid[0] never pulses.

Source files
------------

// File: rtl/iob_mem_tiled_ctrl.sv
// iob_mem_tiled_ctrl: shares one tiled single-address 2-port memory between N_REQ valid/ready masters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module iob_mem_tiled_ctrl #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    mem_w_en,
  output logic                    mem_r_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data_in,
  input  logic [DATA_W-1:0]       mem_data_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_HOLD} state_t;
  state_t state, state_nx;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [IDX_W-1:0]  cmd_id, win;
  logic              grant;
  // Gated by rst_n so req_ready reads 0 while reset is held.
  assign grant = rst_n && state == IDLE && |req_valid;
  assign req_ready = grant ? N_REQ'(1) << win : '0;
`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] last_grant;
  // Scan from farthest to nearest after last_grant so the nearest valid requester wins.
  always_comb begin
    win = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req_valid[(int'(last_grant) + k) % N_REQ]) win = IDX_W'((int'(last_grant) + k) % N_REQ);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= IDX_W'(N_REQ - 1);
    else if (grant) last_grant <= win;
`else
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[k]) win = IDX_W'(k);
  end
`endif
  always_comb begin
    state_nx = state == IDLE  ? (|req_valid ? ISSUE : IDLE) :
               state == ISSUE ? (cmd_we ? IDLE : RD_HOLD) : IDLE;
    mem_w_en = state == ISSUE && cmd_we;
    mem_r_en = state == ISSUE && !cmd_we;
  end
  // Address stays on cmd_addr through RD_HOLD: the memory's bank mux follows the live address.
  assign mem_addr    = cmd_addr;
  assign mem_data_in = cmd_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_id    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= '0;
      if (grant) begin
        cmd_we    <= req_we[win];
        cmd_addr  <= req_addr[win*ADDR_W +: ADDR_W];
        cmd_wdata <= req_wdata[win*DATA_W +: DATA_W];
        cmd_id    <= win;
      end
      if (state == RD_HOLD) begin
        rsp_rdata <= mem_data_out;
        rsp_valid <= N_REQ'(1) << cmd_id;
      end
    end
endmodule

// File: tb/tb_iob_mem_tiled_ctrl.sv
// tb_iob_mem_tiled_ctrl: scoreboard bench for iob_mem_tiled_ctrl with a two-tile memory model.
module tb_iob_mem_tiled_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [29:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mem_data_in, mem_data_out;
  logic        mem_w_en, mem_r_en;
  logic [14:0] mem_addr;
  iob_mem_tiled_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_w_en(mem_w_en),
    .mem_r_en(mem_r_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );
  always #5 clk = ~clk;
  // Tiled memory: one read register per tile, output muxed by live address bit 11.
  logic [31:0] mem [0:32767];
  logic [31:0] bank_q [2];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_data_in;
    if (mem_r_en) bank_q[mem_addr[11]] <= mem[mem_addr];
  end
  assign mem_data_out = bank_q[mem_addr[11]];
  typedef struct {int id; logic we; logic [14:0] addr; logic [31:0] data;} txn_t;
  typedef struct {int due; int id; logic [14:0] addr; logic [31:0] data;} pend_t;
  txn_t  gq[$];
  pend_t wq[$], renq[$], holdq[$], rspq[$];
  int tests = 0, errs = 0, cyc = 0, rsp_seen = 0, n, last, seen0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  txn_t mt;
  pend_t mp;
  logic [1:0] mhs;
  always @(negedge clk) begin
    if (rsp_valid != 0) rsp_seen++;
    if (rst_n) begin
      mhs = req_valid & req_ready;
      if (mhs != 0) begin
        if (gq.size() == 0) check("unexpected_grant", mhs, 0);
        else begin
          mt = gq.pop_front();
          check("grant_id", mhs, 64'(2'b01 << mt.id));
          mp = '{cyc + 1, mt.id, mt.addr, mt.data};
          if (mt.we) wq.push_back(mp);
          else begin
            renq.push_back(mp);
            mp.due = cyc + 3;
            rspq.push_back(mp);
          end
        end
      end
      if (mem_w_en | mem_r_en) check("ready_busy", req_ready, 0);
      if (mem_w_en) begin
        if (wq.size() == 0) check("unexpected_wen", mem_w_en, 0);
        else begin
          mp = wq.pop_front();
          check("wen_cycle", cyc, mp.due);
          check("wen_addr", mem_addr, mp.addr);
          check("wen_data", mem_data_in, mp.data);
          check("wen_ren_excl", mem_r_en, 0);
        end
      end
      if (mem_r_en) begin
        if (renq.size() == 0) check("unexpected_ren", mem_r_en, 0);
        else begin
          mp = renq.pop_front();
          check("ren_cycle", cyc, mp.due);
          check("ren_addr", mem_addr, mp.addr);
          mp.due = cyc + 1;
          holdq.push_back(mp);
        end
      end
      if (holdq.size() > 0 && holdq[0].due == cyc) begin
        mp = holdq.pop_front();
        check("hold_addr", mem_addr, mp.addr);
        check("hold_en", {mem_w_en, mem_r_en}, 0);
      end
      if (rsp_valid != 0) begin
        if (rspq.size() == 0) check("unexpected_rsp", rsp_valid, 0);
        else begin
          mp = rspq.pop_front();
          check("rsp_cycle", cyc, mp.due);
          check("rsp_valid", rsp_valid, 64'(2'b01 << mp.id));
          check("rsp_rdata", rsp_rdata, mp.data);
        end
      end
    end
  end
  task automatic set_req(input int i, input logic we, input logic [14:0] a, input logic [31:0] d);
    req_we[i] = we;
    req_addr[i*15 +: 15] = a;
    req_wdata[i*32 +: 32] = d;
  endtask
  task automatic eg(input int i, input logic we, input logic [14:0] a, input logic [31:0] d);
    gq.push_back('{i, we, a, d});
  endtask
  // Raise valid on the mask and drop each requester's valid right after its handshake.
  task automatic run(input logic [1:0] m);
    logic [1:0] hs;
    req_valid = m;
    for (int c = 0; c < 30 && req_valid != 0; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1 req_valid &= ~hs;
    end
    check("run_timeout", req_valid, 0);
    req_valid = 0;
  endtask
  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_mem", {mem_w_en, mem_r_en, mem_addr, mem_data_in}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    req_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    // Write then read, single requester
    set_req(0, 1, 15'h0010, 32'hDEADBEEF); eg(0, 1, 15'h0010, 32'hDEADBEEF); run(2'b01);
    set_req(0, 0, 15'h0010, 0);            eg(0, 0, 15'h0010, 32'hDEADBEEF); run(2'b01);
    drain();
    // Cross-tile reads back to back
    set_req(1, 1, 15'h0004, 32'h11111111); eg(1, 1, 15'h0004, 32'h11111111); run(2'b10);
    set_req(1, 1, 15'h0804, 32'h22222222); eg(1, 1, 15'h0804, 32'h22222222); run(2'b10);
    set_req(0, 0, 15'h0004, 0);            eg(0, 0, 15'h0004, 32'h11111111); run(2'b01);
    set_req(0, 0, 15'h0804, 0);            eg(0, 0, 15'h0804, 32'h22222222); run(2'b01);
    drain();
    // Contention: both requesters hold valid, both writing
    set_req(0, 1, 15'h0100, 32'hA0A0A0A0);
    set_req(1, 1, 15'h0200, 32'hB1B1B1B1);
`ifdef MEM_ARB_RR_EN
    eg(0, 1, 15'h0100, 32'hA0A0A0A0); eg(1, 1, 15'h0200, 32'hB1B1B1B1);
    eg(0, 1, 15'h0100, 32'hA0A0A0A0); eg(1, 1, 15'h0200, 32'hB1B1B1B1);
`else
    eg(0, 1, 15'h0100, 32'hA0A0A0A0); eg(0, 1, 15'h0100, 32'hA0A0A0A0);
    eg(0, 1, 15'h0100, 32'hA0A0A0A0); eg(1, 1, 15'h0200, 32'hB1B1B1B1);
`endif
    n = 0; last = -1; req_valid = 2'b11;
    for (int c = 0; c < 40 && req_valid != 0; c++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 0) begin
        if (last >= 0) check("grant_gap", cyc - last, 2);
        last = cyc;
        n++;
      end
      @(posedge clk);
      #1;
`ifdef MEM_ARB_RR_EN
      if (n == 4) req_valid = 0;
`else
      if (n >= 3) req_valid[0] = 0;
      if (n == 4) req_valid = 0;
`endif
    end
    check("contention_grants", n, 4);
    req_valid = 0;
    drain();
    // Reset while a read sits in RD_HOLD
    set_req(0, 0, 15'h0010, 0); eg(0, 0, 15'h0010, 0); run(2'b01);
    @(posedge clk);
    #1;
    check("pre_rst_hold", {mem_w_en, mem_r_en, mem_addr}, {2'b00, 15'h0010});
    rst_n = 0;
    #1;
    check("midrst_mem", {mem_w_en, mem_r_en, mem_addr, mem_data_in}, 0);
    check("midrst_out", {req_ready, rsp_valid}, 0);
    holdq.delete();
    rspq.delete();
    seen0 = rsp_seen;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    check("no_rsp_after_rst", rsp_seen - seen0, 0);
    set_req(0, 1, 15'h0300, 32'h33333333); set_req(1, 1, 15'h0304, 32'h44444444);
    eg(0, 1, 15'h0300, 32'h33333333); eg(1, 1, 15'h0304, 32'h44444444);
    run(2'b11);
    drain();
    // Read-after-write ordering across requesters
    set_req(0, 1, 15'h0010, 32'hCAFEF00D); set_req(1, 0, 15'h0010, 0);
    eg(0, 1, 15'h0010, 32'hCAFEF00D); eg(1, 0, 15'h0010, 32'hCAFEF00D);
    run(2'b11);
    drain();
    check("queues_empty", gq.size() + wq.size() + renq.size() + holdq.size() + rspq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
